// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: access width codes, control bundle, bubble constant and alignment helper
package memory_stage_pkg;
    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'b00,
        WIDTH_HALF = 2'b01,
        WIDTH_WORD = 2'b10
    } width_e;
    typedef struct packed {
        logic   reg_write;
        logic   mem_read;
        logic   mem_write;
        logic   mem_to_reg;
        logic   mem_unsigned;
        width_e width;
    } ctrl_t;
    localparam ctrl_t CTRL_BUBBLE = '{reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
                                      mem_to_reg: 1'b0, mem_unsigned: 1'b0, width: WIDTH_BYTE};
    function automatic logic misaligned(input width_e w, input logic [1:0] off);
        return (w == WIDTH_HALF && off[0]) || (w == WIDTH_WORD && off != 2'b00);
    endfunction
endpackage

// File: rtl/memory_stage_if.sv
// memory_stage_if: execute-side bus and debug read port of the memory stage
interface memory_stage_if #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_ADDR = 8
);
    logic               enable_i;
    logic               flush_i;
    logic [NB_DATA-1:0] alu_result_i;
    logic [NB_DATA-1:0] data_rb_i;
    logic [NB_REG-1:0]  writeReg_i;
    logic               mem_read_i;
    logic               mem_write_i;
    logic [1:0]         mem_width_i;
    logic               mem_unsigned_i;
    logic               reg_write_i;
    logic               mem_to_reg_i;
    logic [NB_DATA-1:0] ex_mem_data_o;
    logic [NB_REG-1:0]  ex_mem_reg_o;
    logic               ex_mem_reg_write_o;
    logic [NB_DATA-1:0] mem_wb_data_o;
    logic [NB_REG-1:0]  mem_wb_reg_o;
    logic               mem_wb_reg_write_o;
    logic               misalign_o;
    logic [NB_ADDR-1:0] dbg_addr_i;
    logic [NB_DATA-1:0] dbg_data_o;
    modport slave (
        input  enable_i, flush_i, alu_result_i, data_rb_i, writeReg_i, mem_read_i, mem_write_i,
               mem_width_i, mem_unsigned_i, reg_write_i, mem_to_reg_i, dbg_addr_i,
        output ex_mem_data_o, ex_mem_reg_o, ex_mem_reg_write_o, mem_wb_data_o, mem_wb_reg_o,
               mem_wb_reg_write_o, misalign_o, dbg_data_o
    );
    modport master (
        output enable_i, flush_i, alu_result_i, data_rb_i, writeReg_i, mem_read_i, mem_write_i,
               mem_width_i, mem_unsigned_i, reg_write_i, mem_to_reg_i, dbg_addr_i,
        input  ex_mem_data_o, ex_mem_reg_o, ex_mem_reg_write_o, mem_wb_data_o, mem_wb_reg_o,
               mem_wb_reg_write_o, misalign_o, dbg_data_o
    );
endinterface

// File: rtl/memory_stage_data_memory.sv
// memory_stage_data_memory: synchronous dual-port RAM, port A byte-enabled read/write, port B read-only
module memory_stage_data_memory #(
    parameter int NB_ADDR = 8,
    parameter int NB_DATA = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 a_en,
    input  logic [NB_DATA/8-1:0] a_we,
    input  logic [NB_ADDR-1:0]   a_addr,
    input  logic [NB_DATA-1:0]   a_wdata,
    output logic [NB_DATA-1:0]   a_rdata,
    input  logic [NB_ADDR-1:0]   b_addr,
    output logic [NB_DATA-1:0]   b_rdata
);
    logic [NB_DATA-1:0] mem [2**NB_ADDR];
    always_ff @(posedge clk)
        for (int i = 0; i < NB_DATA/8; i++)
            if (a_we[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
    // read registers return pre-write data on a same-edge collision
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            if (a_en) a_rdata <= mem[a_addr];
            b_rdata <= mem[b_addr];
        end
endmodule

// File: rtl/memory_stage.sv
// memory_stage: EX/MEM register, data memory with lane steering, MEM/WB register and load extension
module memory_stage
    import memory_stage_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_ADDR = 8
) (
    input logic           clock_i,
    input logic           reset_i,
    memory_stage_if.slave bus
);
    ctrl_t              in_ctrl, em_ctrl;
    logic [NB_DATA-1:0] em_data, em_rb, wb_alu, rd_data, wdata, ld_val;
    logic [NB_REG-1:0]  em_reg, wb_reg;
    logic [1:0]         off, wb_off;
    logic [3:0]         lanes, we;
    logic [15:0]        ld_half;
    logic [7:0]         ld_byte;
    logic               mis, wb_mis, wb_rw, wb_m2r, wb_uns;
    width_e             wb_width;
    assign in_ctrl = '{reg_write: bus.reg_write_i, mem_read: bus.mem_read_i, mem_write: bus.mem_write_i,
                       mem_to_reg: bus.mem_to_reg_i, mem_unsigned: bus.mem_unsigned_i,
                       width: width_e'(bus.mem_width_i)};
    assign off   = em_data[1:0];
    assign mis   = misaligned(em_ctrl.width, off);
    assign lanes = em_ctrl.width == WIDTH_WORD ? 4'b1111 :
                   em_ctrl.width == WIDTH_HALF ? 4'b0011 << off : 4'b0001 << off;
    assign we    = (bus.enable_i && em_ctrl.mem_write && !mis) ? lanes : 4'b0000;
    assign wdata = em_ctrl.width == WIDTH_WORD ? em_rb :
                   em_ctrl.width == WIDTH_HALF ? {2{em_rb[15:0]}} : {4{em_rb[7:0]}};
    memory_stage_data_memory #(.NB_ADDR(NB_ADDR), .NB_DATA(NB_DATA)) u_mem (
        .clk    (clock_i),
        .rst_n  (reset_i),
        .a_en   (bus.enable_i && em_ctrl.mem_read),
        .a_we   (we),
        .a_addr (em_data[NB_ADDR+1:2]),
        .a_wdata(wdata),
        .a_rdata(rd_data),
        .b_addr (bus.dbg_addr_i),
        .b_rdata(bus.dbg_data_o)
    );
    always_ff @(posedge clock_i or negedge reset_i)
        if (!reset_i) begin
            em_data  <= '0;
            em_rb    <= '0;
            em_reg   <= '0;
            em_ctrl  <= CTRL_BUBBLE;
            wb_alu   <= '0;
            wb_reg   <= '0;
            wb_rw    <= 1'b0;
            wb_m2r   <= 1'b0;
            wb_off   <= 2'b00;
            wb_width <= WIDTH_BYTE;
            wb_uns   <= 1'b0;
            wb_mis   <= 1'b0;
        end else if (bus.enable_i) begin
            em_data  <= bus.flush_i ? '0 : bus.alu_result_i;
            em_rb    <= bus.flush_i ? '0 : bus.data_rb_i;
            em_reg   <= bus.flush_i ? '0 : bus.writeReg_i;
            em_ctrl  <= bus.flush_i ? CTRL_BUBBLE : in_ctrl;
            wb_alu   <= em_data;
            wb_reg   <= em_reg;
            wb_rw    <= em_ctrl.reg_write;
            wb_m2r   <= em_ctrl.mem_to_reg;
            wb_off   <= off;
            wb_width <= em_ctrl.width;
            wb_uns   <= em_ctrl.mem_unsigned;
            wb_mis   <= mis && (em_ctrl.mem_read || em_ctrl.mem_write);
        end
    // lane extraction and extension happen after MEM/WB, on the registered read word
    assign ld_half = wb_off[1] ? rd_data[31:16] : rd_data[15:0];
    assign ld_byte = rd_data[{wb_off, 3'b000} +: 8];
    assign ld_val  = wb_mis ? '0 :
                     wb_width == WIDTH_WORD ? rd_data :
                     wb_width == WIDTH_HALF ? {{16{~wb_uns & ld_half[15]}}, ld_half} :
                                              {{24{~wb_uns & ld_byte[7]}}, ld_byte};
    assign bus.ex_mem_data_o      = em_data;
    assign bus.ex_mem_reg_o       = em_reg;
    assign bus.ex_mem_reg_write_o = em_ctrl.reg_write;
    assign bus.mem_wb_data_o      = wb_m2r ? ld_val : wb_alu;
    assign bus.mem_wb_reg_o       = wb_reg;
    assign bus.mem_wb_reg_write_o = wb_rw;
    assign bus.misalign_o         = wb_mis;
endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage: holds the EX/MEM pipeline register, the data memory, and the MEM/WB pipeline register.
- Consumes the ALU result, forwarded store data and destination register from execute.
- Returns ex_mem_data and mem_wb_data to execute's forwarding multiplexers.
- Supports byte, half and word loads/stores with sign/zero extension, a debug read port for the FPGA debug unit, and stall/flush control.

Parameters:
- NB_DATA, 32, datapath width.
- NB_REG, 5, register index width.
- NB_ADDR, 8, data memory word-address width (256 words).

Ports:
- clock_i  in  1  system clock
- reset_i  in  1  asynchronous active-low reset
- enable_i  in  1  pipeline advance (0 = stall/debug step hold)
- flush_i  in  1  load a bubble into EX/MEM on next enabled edge
- alu_result_i  in  NB_DATA  byte address / ALU result from execute
- data_rb_i  in  NB_DATA  store data (post-forwarding)
- writeReg_i  in  NB_REG  destination register
- mem_read_i  in  1  load
- mem_write_i  in  1  store
- mem_width_i  in  2  00 byte, 01 half, 10 word
- mem_unsigned_i  in  1  zero-extend loads
- reg_write_i  in  1  writeback enable
- mem_to_reg_i  in  1  writeback selects memory data
- ex_mem_data_o  out  NB_DATA  EX/MEM ALU result (forwarding source)
- ex_mem_reg_o  out  NB_REG  EX/MEM destination
- ex_mem_reg_write_o  out  1  EX/MEM reg_write
- mem_wb_data_o  out  NB_DATA  final writeback data (forwarding source)
- mem_wb_reg_o  out  NB_REG  MEM/WB destination
- mem_wb_reg_write_o  out  1  MEM/WB reg_write
- misalign_o  out  1  misaligned access in MEM/WB
- dbg_addr_i  in  NB_ADDR  debug word address
- dbg_data_o  out  NB_DATA  debug read data, one cycle latency

Behaviour:
- Reset (reset_i low, asynchronous): all EX/MEM and MEM/WB fields, misalign_o and dbg_data_o go to 0. Memory contents are not cleared.
- EX/MEM latch:
  - On rising edge with enable_i=1, capture all inputs.
  - If flush_i=1 in that cycle, capture a bubble instead: reg_write, mem_read, mem_write = 0; other fields don't-care but cleared to 0.
  - enable_i=0 holds both registers and blocks memory writes.
- Address:
  - word address = ex_mem addr[NB_ADDR+1:2]; byte offset = addr[1:0].
  - Upper address bits are ignored, so addresses wrap modulo 4*2^NB_ADDR.
- Misalignment:
  - Half access with offset[0]=1 is misaligned; word access with offset≠0 is misaligned.
  - A misaligned store is suppressed (no byte enables).
  - A misaligned load returns 0.
  - In both cases misalign_o=1 in the MEM/WB cycle.
- Store:
  - Synchronous write on the enabled edge while the access is in EX/MEM.
  - Byte enables: byte → 1 lane at offset, data_rb[7:0] replicated; half → lanes offset, offset+1; word → all lanes.
- Load:
  - Synchronous read on the same edge that loads MEM/WB.
  - MEM/WB also registers offset, width and unsigned.
  - Extraction and extension are combinational after MEM/WB: byte/half is selected by offset and sign-extended unless unsigned.
- Latency: result reaches mem_wb_data_o exactly 2 enabled edges after the instruction is present at the inputs.
- Writeback mux: mem_wb_data_o = mem_to_reg ? extended load : registered ALU result.
- Read-after-write, store then load to same word on consecutive instructions: the load observes the new data (write precedes read by one edge).
- Debug port:
  - Independent second read port, active regardless of enable_i.
  - dbg_data_o is registered one edge after dbg_addr_i.
  - A simultaneous store to the same word returns the old data.
- Reset mid-operation: pipeline contents are dropped; a store in EX/MEM at the reset edge is not written.

Decomposition:
- Shared package: width codes (WIDTH_BYTE=2'b00, WIDTH_HALF=2'b01, WIDTH_WORD=2'b10) and the bubble constant.
- Sub-module data_memory: dual-port RAM (port A read/write with 4 byte enables, port B read-only debug), synchronous, NB_ADDR/NB_DATA parameters.
- Alignment, lane steering and extension stay in memory_stage.

Test Plan:
- Reset: assert reset_i low mid-cycle → all outputs 0 immediately. A store pending at reset leaves memory unchanged, confirmed by debug read.
- Word store then load: sw 0xDEADBEEF to addr 0x10, then lw from 0x10 → mem_wb_data_o = 0xDEADBEEF, 2 edges after the load is presented.
- Byte/half extension: word 0x80FF7F01 at 0x20.
  - lb offsets 0..3 → 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80.
  - lbu offset 3 → 0x00000080.
  - lh 0x22 → 0xFFFF80FF.
  - lhu 0x22 → 0x000080FF.
- Partial store: sb 0xAB at 0x31 over word 0x11223344 → word reads 0x1122AB44. sh 0x5566 at 0x32 → word reads 0x5566AB44.
- Misalignment: sw to 0x41 → memory unchanged and misalign_o=1. lh from 0x43 → mem_wb_data_o=0 and misalign_o=1.
- Stall/flush:
  - With enable_i=0 for 3 cycles, outputs hold.
  - flush_i on a store → no write and reg_write out=0.
  - ALU-only instruction (mem_to_reg=0, result 0x1234) → ex_mem_data_o=0x1234 after 1 edge, mem_wb_data_o=0x1234 after 2 edges.
